// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: walks a 3-input gate through rows 000..111, letting each
// row settle before sampling, then reports the measured table against a latched reference.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       gate_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed,
    output logic [7:0] mismatch,
    output logic [7:0] fail_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] work_q, work_d;
    logic [2:0] in_q, in_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] obs_q, obs_d;
    logic [7:0] mis_q, mis_d;
    logic [7:0] fail_q, fail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            work_q  <= '0;
            in_q    <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            obs_q   <= '0;
            mis_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            work_q  <= work_d;
            in_q    <= in_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            obs_q   <= obs_d;
            mis_q   <= mis_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        work_d  = work_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        obs_d   = obs_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    row_d   = '0;
                    cnt_d   = RELOAD;
                    exp_d   = expected;
                    work_d  = '0;
                end
            end
            SETTLE: begin
                if (abort)              state_d = IDLE;
                else if (cnt_q == 8'd0) state_d = SAMPLE;
                else                    cnt_d   = cnt_q - 8'd1;
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Row 0 lands in the MSB so the table reads left-to-right as 000..111.
                    work_d[3'd7 - row_q] = gate_out;
                    if (row_q != 3'd7) begin
                        row_d   = row_q + 3'd1;
                        cnt_d   = RELOAD;
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                obs_d   = work_q;
                mis_d   = work_q ^ exp_q;
                pass_d  = (work_q == exp_q);
                if (work_q != exp_q && fail_q != 8'hFF) fail_d = fail_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        // Gate inputs follow the row only while a row is being driven; parked at 000 otherwise.
        in_d = (state_d == SETTLE || state_d == SAMPLE) ? row_d : 3'd0;
    end

    assign {in1, in2, in3} = in_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign observed   = obs_q;
    assign mismatch   = mis_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: random gates/references/aborts against a sweep-level model,
// plus reset, saturation and a SETTLE_CYCLES=1 instance.
module tb_tt_sweep_ctrl;

    localparam int S    = 4;
    localparam int ROWP = S + 1;
    localparam int LAT  = 8 * ROWP + 1;

    logic clk = 1'b0;
    logic rst_n, start, abort, start1;
    logic [7:0] expected, expected1, gate_tt;
    logic gate_out, gate1_out;
    logic in1, in2, in3, busy, done, pass;
    logic [7:0] observed, mismatch, fail_count;
    logic a1, b1, c1, busy1, done1, pass1;
    logic [7:0] observed1, mismatch1, fail_count1;

    always #5 clk = ~clk;

    tt_sweep_ctrl #(.SETTLE_CYCLES(S)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .gate_out(gate_out), .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
        .pass(pass), .observed(observed), .mismatch(mismatch), .fail_count(fail_count));

    tt_sweep_ctrl #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .expected(expected1),
        .gate_out(gate1_out), .in1(a1), .in2(b1), .in3(c1), .busy(busy1), .done(done1),
        .pass(pass1), .observed(observed1), .mismatch(mismatch1), .fail_count(fail_count1));

    // Gate under test: a lookup whose row 000 is the table MSB.
    logic [2:0] idx0, idx1;
    assign idx0      = 3'd7 - {in1, in2, in3};
    assign idx1      = 3'd7 - {a1, b1, c1};
    assign gate_out  = gate_tt[idx0];
    assign gate1_out = gate_tt[idx1];

    typedef struct {
        logic [7:0] obs;
        logic [7:0] mis;
        logic       pas;
        logic [7:0] fc;
        int         dc;
    } item_t;

    item_t sbq[$];
    int    cyc = 0;
    int    n_cmp = 0, n_bad = 0;
    int    E = 0;
    bit    active = 0;
    logic [7:0] m_obs = 0, m_fail = 0;
    logic       m_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: compares each done pulse with the oldest predicted sweep, and the row drive pattern.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    item_t it;
                    it = sbq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(it.dc));
                    chk("observed", 32'(observed), 32'(it.obs));
                    chk("mismatch", 32'(mismatch), 32'(it.mis));
                    chk("pass", 32'(pass), 32'(it.pas));
                    chk("fail_count", 32'(fail_count), 32'(it.fc));
                end
            end
            if (active && (cyc - E) <= 8 * ROWP) begin
                int t;
                t = cyc - E;
                chk("row_drive", 32'({in1, in2, in3}), (t < 8 * ROWP) ? 32'(t / ROWP) : 32'd0);
                chk("busy_in_sweep", 32'(busy), 32'd1);
            end
        end
    end

    // One sweep from an idle DUT; abort_at>0 aborts at that edge after acceptance.
    task automatic run_sweep(input logic [7:0] gt, input logic [7:0] ex, input int abort_at,
                             input bit hold);
        gate_tt  = gt;
        expected = ex;
        start    = 1'b1;
        abort    = 1'b0;
        @(negedge clk);
        E      = cyc;
        active = 1;
        if (!hold) start = 1'b0;
        expected = 8'($urandom);
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort  = 1'b0;
            active = 0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_in", 32'({in1, in2, in3}), 32'd0);
            chk("abort_observed", 32'(observed), 32'(m_obs));
            chk("abort_pass", 32'(pass), 32'(m_pass));
            chk("abort_fail_count", 32'(fail_count), 32'(m_fail));
        end else begin
            item_t it;
            it.obs = gt;
            it.mis = gt ^ ex;
            it.pas = (gt == ex);
            if (!it.pas && m_fail != 8'd255) m_fail = m_fail + 8'd1;
            it.fc  = m_fail;
            it.dc  = E + LAT;
            m_obs  = gt;
            m_pass = it.pas;
            sbq.push_back(it);
            repeat (LAT) @(negedge clk);
            active = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0;
        expected = 8'h00; expected1 = 8'h00; gate_tt = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_observed", 32'(observed), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        chk("rst_in", 32'({in1, in2, in3}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(8'h6B, 8'h6B, 0, 0);
        run_sweep(8'h6B, 8'h6A, 0, 0);
        run_sweep(8'h6B, 8'h00, 27, 0);   // abort while row 5 is settling

        for (int i = 0; i < 30; i++) begin
            logic [7:0] gt, ex;
            int ab;
            gt = 8'($urandom);
            ex = ($urandom_range(0, 2) == 0) ? gt : 8'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8 * ROWP)) : 0;
            run_sweep(gt, ex, ab, 1'($urandom_range(0, 1)));
        end
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 260; i++) begin
            logic [7:0] gt;
            gt = 8'($urandom);
            run_sweep(gt, gt ^ 8'h01, 0, 1);
        end
        start = 1'b0;
        chk("fail_count_saturated", 32'(fail_count), 32'd255);
        @(negedge clk);

        // Reset in the middle of row 3 discards the sweep.
        gate_tt = 8'h6B; expected = 8'h6B; start = 1'b1;
        @(negedge clk);
        E = cyc; active = 1; start = 1'b0;
        repeat (3 * ROWP + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        active = 0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in", 32'({in1, in2, in3}), 32'd0);
        chk("midrst_observed", 32'(observed), 32'd0);
        chk("midrst_mismatch", 32'(mismatch), 32'd0);
        chk("midrst_pass", 32'(pass), 32'd0);
        chk("midrst_fail_count", 32'(fail_count), 32'd0);
        m_obs = 0; m_pass = 0; m_fail = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        run_sweep(8'h6B, 8'h6B, 0, 0);
        run_sweep(8'hC5, 8'h3A, 0, 0);

        // SETTLE_CYCLES=1 instance: each row lasts two cycles, done 17 edges after accept.
        begin
            int e1, waited;
            gate_tt = 8'($urandom); expected1 = gate_tt; start1 = 1'b1;
            @(negedge clk);
            e1 = cyc; start1 = 1'b0; expected1 = ~gate_tt;
            waited = 0;
            while (!done1 && waited < 40) begin
                @(negedge clk);
                waited++;
                if (!done1 && (cyc - e1) < 16)
                    chk("s1_row_drive", 32'({a1, b1, c1}), 32'((cyc - e1) / 2));
            end
            chk("s1_done_seen", 32'(done1), 32'd1);
            chk("s1_done_cycle", 32'(cyc - e1), 32'd17);
            chk("s1_observed", 32'(observed1), 32'(gate_tt));
            chk("s1_pass", 32'(pass1), 32'd1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
